// File: rtl/seq_arith_unit_if.sv
// Request/response bundle for seq_arith_unit.
// Defining SEQ_ARITH_HI_EN adds the result_hi_o return field.
interface seq_arith_unit_if #(
  parameter int N = 32
);
  logic         valid_i;
  logic         ready_o;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  logic [2:0]   opcode_i;
  logic         valid_o;
  logic [N-1:0] result_o;
  logic         cout_o;
  logic         overflow_o;
  logic         zero_o;
  logic         negative_o;
  logic         div0_o;
`ifdef SEQ_ARITH_HI_EN
  logic [N-1:0] result_hi_o;

  modport master (
    output valid_i, a_i, b_i, opcode_i,
    input  ready_o, valid_o, result_o, cout_o, overflow_o, zero_o,
           negative_o, div0_o, result_hi_o
  );

  modport slave (
    input  valid_i, a_i, b_i, opcode_i,
    output ready_o, valid_o, result_o, cout_o, overflow_o, zero_o,
           negative_o, div0_o, result_hi_o
  );
`else
  modport master (
    output valid_i, a_i, b_i, opcode_i,
    input  ready_o, valid_o, result_o, cout_o, overflow_o, zero_o,
           negative_o, div0_o
  );

  modport slave (
    input  valid_i, a_i, b_i, opcode_i,
    output ready_o, valid_o, result_o, cout_o, overflow_o, zero_o,
           negative_o, div0_o
  );
`endif
endinterface

// File: rtl/seq_arith_unit.sv
// Execute-stage arithmetic unit: registered ADD/SUB/MOV, iterative unsigned MUL/DIVU/REMU.
// Optional macro SEQ_ARITH_HI_EN adds result_hi_o (product high half / other of quotient-remainder).
module seq_arith_unit #(
  parameter  int N     = 32,
  localparam int CNT_W = $clog2(N + 1)
) (
  input logic             clk_i,
  input logic             rst_i,
  seq_arith_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_MUL = 2'd1,
    RUN_DIV = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b100;
  localparam logic [2:0] OP_REMU = 3'b101;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0] cnt;
  logic [2*N-1:0]   acc;
  logic [2*N-1:0]   acc_next;
  logic [N-1:0]     opd;
  logic             rem_sel;

  logic [N-1:0] result_q;
  logic         cout_q;
  logic         overflow_q;
  logic         div0_q;
  logic         valid_q;
`ifdef SEQ_ARITH_HI_EN
  logic [N-1:0] result_hi_q;
  logic [N-1:0] imm_hi;
`endif

  logic ready;
  logic accept;
  logic last_iter;

  logic [N:0]   add_sum;
  logic [N-1:0] sub_diff;
  logic         imm_done;
  logic [N-1:0] imm_res;
  logic         imm_cout;
  logic         imm_ov;
  logic         imm_div0;

  logic [N:0] mul_sum;
  logic [N:0] div_trial;
  logic [N:0] div_diff;

  assign ready     = (state == IDLE);
  assign accept    = bus.valid_i && ready;
  assign last_iter = (cnt == CNT_LAST);

  // Single-cycle results; imm_done is low for ops that must iterate.
  always_comb begin
    add_sum  = {1'b0, bus.a_i} + {1'b0, bus.b_i};
    sub_diff = bus.a_i - bus.b_i;
    imm_done = 1'b1;
    imm_res  = '0;
    imm_cout = 1'b0;
    imm_ov   = 1'b0;
    imm_div0 = 1'b0;
`ifdef SEQ_ARITH_HI_EN
    imm_hi   = '0;
`endif
    case (bus.opcode_i)
      OP_ADD: begin
        imm_res  = add_sum[N-1:0];
        imm_cout = add_sum[N];
        imm_ov   = ~(bus.a_i[N-1] ^ bus.b_i[N-1]) & (add_sum[N-1] ^ bus.a_i[N-1]);
      end
      OP_SUB: begin
        imm_res  = sub_diff;
        imm_cout = (bus.a_i < bus.b_i);
        imm_ov   = (bus.a_i[N-1] ^ bus.b_i[N-1]) & (sub_diff[N-1] ^ bus.a_i[N-1]);
      end
      OP_MOV: begin
        imm_res = bus.b_i;
      end
      OP_MUL: begin
        imm_done = 1'b0;
      end
      OP_DIVU: begin
        if (bus.b_i == '0) begin
          imm_res  = '1;
          imm_div0 = 1'b1;
`ifdef SEQ_ARITH_HI_EN
          imm_hi   = bus.a_i;
`endif
        end else begin
          imm_done = 1'b0;
        end
      end
      OP_REMU: begin
        if (bus.b_i == '0) begin
          imm_res  = bus.a_i;
          imm_div0 = 1'b1;
`ifdef SEQ_ARITH_HI_EN
          imm_hi   = '1;
`endif
        end else begin
          imm_done = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  // One iteration step: MUL shifts {carry, hi, lo} right, DIV shifts the
  // remainder:dividend pair left and restores when the trial subtract borrows.
  always_comb begin
    mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opd} : {(N+1){1'b0}});
    div_trial = {acc[2*N-1:N], acc[N-1]};
    div_diff  = div_trial - {1'b0, opd};
    acc_next  = acc;
    if (state == RUN_MUL) begin
      acc_next = {mul_sum, acc[N-1:1]};
    end else if (state == RUN_DIV) begin
      if (div_diff[N]) begin
        acc_next = {div_trial[N-1:0], acc[N-2:0], 1'b0};
      end else begin
        acc_next = {div_diff[N-1:0], acc[N-2:0], 1'b1};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && !imm_done) begin
          state_next = (bus.opcode_i == OP_MUL) ? RUN_MUL : RUN_DIV;
        end
      end
      RUN_MUL, RUN_DIV: begin
        if (last_iter) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Completion writes result/flags and raises valid for exactly one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt        <= '0;
      acc        <= '0;
      opd        <= '0;
      rem_sel    <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      div0_q     <= 1'b0;
      valid_q    <= 1'b0;
`ifdef SEQ_ARITH_HI_EN
      result_hi_q <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        if (imm_done) begin
          result_q   <= imm_res;
          cout_q     <= imm_cout;
          overflow_q <= imm_ov;
          div0_q     <= imm_div0;
          valid_q    <= 1'b1;
`ifdef SEQ_ARITH_HI_EN
          result_hi_q <= imm_hi;
`endif
        end else begin
          cnt     <= CNT_INIT;
          rem_sel <= (bus.opcode_i == OP_REMU);
          if (bus.opcode_i == OP_MUL) begin
            acc <= {{N{1'b0}}, bus.b_i};
            opd <= bus.a_i;
          end else begin
            acc <= {{N{1'b0}}, bus.a_i};
            opd <= bus.b_i;
          end
        end
      end else if (state != IDLE) begin
        acc <= acc_next;
        cnt <= cnt - CNT_LAST;
        if (last_iter) begin
          valid_q    <= 1'b1;
          overflow_q <= 1'b0;
          div0_q     <= 1'b0;
          if (state == RUN_MUL) begin
            result_q <= acc_next[N-1:0];
            cout_q   <= |acc_next[2*N-1:N];
`ifdef SEQ_ARITH_HI_EN
            result_hi_q <= acc_next[2*N-1:N];
`endif
          end else begin
            cout_q   <= 1'b0;
            result_q <= rem_sel ? acc_next[2*N-1:N] : acc_next[N-1:0];
`ifdef SEQ_ARITH_HI_EN
            result_hi_q <= rem_sel ? acc_next[N-1:0] : acc_next[2*N-1:N];
`endif
          end
        end
      end
    end
  end

  assign bus.ready_o    = ready;
  assign bus.valid_o    = valid_q;
  assign bus.result_o   = result_q;
  assign bus.cout_o     = cout_q;
  assign bus.overflow_o = overflow_q;
  assign bus.div0_o     = div0_q;
  assign bus.zero_o     = (result_q == '0);
  assign bus.negative_o = result_q[N-1];
`ifdef SEQ_ARITH_HI_EN
  assign bus.result_hi_o = result_hi_q;
`endif

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed bench for seq_arith_unit at N=8 with hand-computed expected values.
// Covers the result_hi_o field too when SEQ_ARITH_HI_EN is defined.
module tb_seq_arith_unit;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b100;
  localparam logic [2:0] OP_REMU = 3'b101;
  localparam logic [2:0] OP_RSV  = 3'b110;

  logic clk;
  logic rst;
  int   errorCount;
  int   checkCount;
  int   lat;
  int   busy;
  int   pulses;

  seq_arith_unit_if #(.N(8)) bus ();

  seq_arith_unit #(.N(8)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkResult(input string tag, input logic [7:0] res, input logic cout,
                             input logic ov, input logic zero, input logic neg, input logic div0);
    checkOutput({tag, "_valid"}, 32'(bus.valid_o), 32'd1);
    checkOutput({tag, "_result"}, 32'(bus.result_o), 32'(res));
    checkOutput({tag, "_cout"}, 32'(bus.cout_o), 32'(cout));
    checkOutput({tag, "_ovf"}, 32'(bus.overflow_o), 32'(ov));
    checkOutput({tag, "_zero"}, 32'(bus.zero_o), 32'(zero));
    checkOutput({tag, "_neg"}, 32'(bus.negative_o), 32'(neg));
    checkOutput({tag, "_div0"}, 32'(bus.div0_o), 32'(div0));
  endtask

  task automatic checkHi(input string tag, input logic [7:0] hi);
`ifdef SEQ_ARITH_HI_EN
    checkOutput({tag, "_hi"}, 32'(bus.result_hi_o), 32'(hi));
`else
    if (hi === 8'hxx) $display("[TB] unreachable");
`endif
  endtask

  // Drives one request and waits (bounded) for its completion pulse.
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                               input bit holdAdd, output int latency, output int busyCycles);
    @(negedge clk);
    bus.valid_i  = 1'b1;
    bus.opcode_i = op;
    bus.a_i      = a;
    bus.b_i      = b;
    latency      = 0;
    busyCycles   = 0;
    while (1) begin
      @(negedge clk);
      latency++;
      if (latency == 1) begin
        if (holdAdd) begin
          bus.opcode_i = OP_ADD;
          bus.a_i      = 8'h01;
          bus.b_i      = 8'h01;
        end else begin
          bus.valid_i = 1'b0;
        end
      end
      if (bus.valid_o) begin
        bus.valid_i = 1'b0;
        break;
      end
      if (!bus.ready_o) busyCycles++;
      if (latency >= 40) begin
        bus.valid_i = 1'b0;
        checkOutput("timeout_valid", 32'(bus.valid_o), 32'd1);
        break;
      end
    end
  endtask

  task automatic checkIdleNext(input string tag);
    @(negedge clk);
    checkOutput({tag, "_no_extra_valid"}, 32'(bus.valid_o), 32'd0);
    checkOutput({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
  endtask

  initial begin
    errorCount   = 0;
    checkCount   = 0;
    rst          = 1'b1;
    bus.valid_i  = 1'b0;
    bus.opcode_i = 3'b000;
    bus.a_i      = 8'h00;
    bus.b_i      = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(bus.ready_o), 32'd1);
    checkOutput("rst_valid", 32'(bus.valid_o), 32'd0);
    checkOutput("rst_result", 32'(bus.result_o), 32'd0);
    checkOutput("rst_cout", 32'(bus.cout_o), 32'd0);
    checkOutput("rst_ovf", 32'(bus.overflow_o), 32'd0);
    checkOutput("rst_div0", 32'(bus.div0_o), 32'd0);
    checkHi("rst", 8'h00);
    rst = 1'b0;

    $display("[TB] back-to-back ADD, SUB, MOV");
    @(negedge clk);
    bus.valid_i = 1'b1; bus.opcode_i = OP_ADD; bus.a_i = 8'h7F; bus.b_i = 8'h01;
    @(negedge clk);
    checkResult("add_ovf", 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkHi("add_ovf", 8'h00);
    bus.opcode_i = OP_SUB; bus.a_i = 8'h00; bus.b_i = 8'h01;
    @(negedge clk);
    checkResult("sub_borrow", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.opcode_i = OP_MOV; bus.a_i = 8'h55; bus.b_i = 8'h00;
    @(negedge clk);
    checkResult("mov_zero", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.valid_i = 1'b0;
    checkIdleNext("mov");

    applyStimulus(OP_ADD, 8'hFF, 8'h01, 1'b0, lat, busy);
    checkResult("add_carry", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(OP_SUB, 8'h80, 8'h01, 1'b0, lat, busy);
    checkResult("sub_ovf", 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(OP_RSV, 8'h05, 8'h03, 1'b0, lat, busy);
    checkOutput("rsv_latency", 32'(lat), 32'd1);
    checkResult("rsv", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("[TB] MUL with request held while busy");
    applyStimulus(OP_MUL, 8'h10, 8'h11, 1'b1, lat, busy);
    checkOutput("mul_latency", 32'(lat), 32'd9);
    checkOutput("mul_busy", 32'(busy), 32'd8);
    checkOutput("mul_ready_at_done", 32'(bus.ready_o), 32'd1);
    checkResult("mul", 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkHi("mul", 8'h01);
    checkIdleNext("mul");

    applyStimulus(OP_MUL, 8'h0D, 8'h0B, 1'b0, lat, busy);
    checkResult("mul_small", 8'h8F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkHi("mul_small", 8'h00);

    $display("[TB] divide and remainder");
    applyStimulus(OP_DIVU, 8'h64, 8'h07, 1'b0, lat, busy);
    checkOutput("divu_latency", 32'(lat), 32'd9);
    checkResult("divu", 8'h0E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkHi("divu", 8'h02);
    applyStimulus(OP_REMU, 8'h64, 8'h07, 1'b0, lat, busy);
    checkOutput("remu_latency", 32'(lat), 32'd9);
    checkResult("remu", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkHi("remu", 8'h0E);
    applyStimulus(OP_DIVU, 8'hFF, 8'h10, 1'b0, lat, busy);
    checkResult("divu_big", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkHi("divu_big", 8'h0F);

    applyStimulus(OP_DIVU, 8'h35, 8'h00, 1'b0, lat, busy);
    checkOutput("divu0_latency", 32'(lat), 32'd1);
    checkResult("divu0", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkHi("divu0", 8'h35);
    applyStimulus(OP_REMU, 8'h35, 8'h00, 1'b0, lat, busy);
    checkOutput("remu0_latency", 32'(lat), 32'd1);
    checkResult("remu0", 8'h35, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkHi("remu0", 8'hFF);
    checkIdleNext("remu0");

    $display("[TB] reset during MUL");
    @(negedge clk);
    bus.valid_i = 1'b1; bus.opcode_i = OP_MUL; bus.a_i = 8'h03; bus.b_i = 8'h05;
    @(negedge clk);
    bus.valid_i = 1'b0;
    checkOutput("abort_busy1", 32'(bus.ready_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_ready", 32'(bus.ready_o), 32'd1);
    checkOutput("abort_valid", 32'(bus.valid_o), 32'd0);
    checkOutput("abort_result", 32'(bus.result_o), 32'd0);
    checkOutput("abort_cout", 32'(bus.cout_o), 32'd0);
    checkOutput("abort_ovf", 32'(bus.overflow_o), 32'd0);
    checkOutput("abort_neg", 32'(bus.negative_o), 32'd0);
    checkOutput("abort_div0", 32'(bus.div0_o), 32'd0);
    checkHi("abort", 8'h00);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.valid_o) pulses++;
    end
    checkOutput("abort_no_pulse", 32'(pulses), 32'd0);

    applyStimulus(OP_ADD, 8'h12, 8'h34, 1'b0, lat, busy);
    checkResult("add_after_rst", 8'h46, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/seq_arith_unit.md
Name: seq_arith_unit

Overview:
Parametrised, handshaked arithmetic unit for the CPU execute stage. Single-cycle ADD/SUB/MOV results are registered. Unsigned MUL, DIVU and REMU run iteratively over N cycles. Produces carry, overflow, zero, negative and divide-by-zero flags for the flags register, and stalls the pipeline through ready_o while an iterative op is running.

Parameters:
N, 32, operand/result width in bits (N >= 4)
CNT_W, $clog2(N+1), iteration counter width (derived, do not override)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
valid_i  in  1  operation request
ready_o  out  1  unit can accept a request this cycle
a_i  in  N  operand A (minuend / multiplicand / dividend)
b_i  in  N  operand B (subtrahend / multiplier / divisor)
opcode_i  in  3  000 ADD, 001 SUB, 010 MOV, 011 MUL, 100 DIVU, 101 REMU, 110/111 reserved
valid_o  out  1  one-cycle pulse, result and flags valid
result_o  out  N  result, held until the next completion
cout_o  out  1  ADD: carry out; SUB: borrow (a<b unsigned); MUL: high half nonzero; else 0
overflow_o  out  1  signed overflow for ADD/SUB; else 0
zero_o  out  1  result_o == 0
negative_o  out  1  result_o[N-1]
div0_o  out  1  DIVU/REMU with b_i == 0

Behaviour:
- Reset (synchronous, rst_i high at the edge):
  - state IDLE; ready_o=1; valid_o=0.
  - result_o and all flags = 0; counter and working registers = 0.
  - Reset wins over any simultaneous request.
- Accept: valid_i && ready_o at a rising edge. Operands and opcode are captured at that edge. Inputs are ignored when ready_o=0.
- States:
  - IDLE: ready_o=1.
  - RUN_MUL, RUN_DIV: ready_o=0.
  - There is no separate DONE state. Completion returns to IDLE and pulses valid_o in the same cycle.
- ADD/SUB/MOV/reserved:
  - Result registered on the accept edge; valid_o high in the following cycle (latency 1); state stays IDLE.
  - Back-to-back accepts every cycle are allowed.
- ADD: {c,r} = a+b (N+1 bits); cout=c; overflow = ~(a[N-1]^b[N-1]) & (r[N-1]^a[N-1]).
- SUB: r = a-b mod 2^N; cout = (a<b unsigned); overflow = (a[N-1]^b[N-1]) & (r[N-1]^a[N-1]).
- MOV: r=b; cout=0; overflow=0.
- Reserved opcodes: r=0, all flags except zero_o = 0, zero_o=1; valid_o still pulses.
- MUL (unsigned shift-add):
  - 2N-bit accumulator, one multiplier bit per cycle; counter loaded with N on accept.
  - Completes on the edge where the counter reaches 0. valid_o is high in the cycle after the Nth iteration (latency N+1 from accept), with ready_o=1 in that same cycle.
  - result = low N bits; cout = |high N bits.
- DIVU/REMU (unsigned restoring):
  - N iterations; latency N+1.
  - DIVU result = quotient; REMU result = remainder; cout=overflow=0.
- Divide by zero:
  - Detected at accept; no iteration; latency 1.
  - DIVU result = all ones; REMU result = a; div0_o=1.
- div0_o is 0 for all other completions.
- zero_o and negative_o are always derived from the registered result_o.
- valid_o is never high for more than one cycle per accepted op. Exactly one valid_o pulse per accept; no pulse for requests not accepted.
- Outputs are stable between completions; no glitching of result_o during RUN states.
- A new request may be accepted in the same cycle valid_o pulses for the previous op (ready_o=1).
- Reset mid-RUN aborts the op: no valid_o; return to IDLE with reset values.

Optional Feature:
SEQ_ARITH_HI_EN
- Defined:
  - Adds output result_hi_o [N-1:0], registered alongside result_o and held until the next completion.
  - MUL: result_hi_o = high N bits of the product.
  - DIVU/REMU: result_hi_o = the other of quotient/remainder (remainder for DIVU, quotient for REMU; for divide by zero: a for DIVU, all ones for REMU).
  - All other ops: result_hi_o = 0. Reset value 0.
- Undefined: the port and its registers do not exist; all other behaviour is identical.

Test Plan:
- N=8, ADD a=0x7F b=0x01 -> next cycle: valid_o=1, result_o=0x80, overflow_o=1, cout_o=0, negative_o=1, zero_o=0.
- N=8, SUB a=0x00 b=0x01 -> result_o=0xFF, cout_o=1, overflow_o=0. Then back-to-back MOV b=0x00 on the next cycle -> result_o=0x00, zero_o=1, two consecutive valid_o pulses.
- N=8, MUL a=0x10 b=0x11 -> ready_o=0 for 8 cycles; valid_i with ADD held during busy produces no accept; valid_o 9 cycles after accept; result_o=0x10, cout_o=1 (result_hi_o=0x01 when SEQ_ARITH_HI_EN).
- N=8, DIVU a=0x64 b=0x07 -> latency 9, result_o=0x0E. REMU with the same operands -> result_o=0x02, div0_o=0.
- N=8, DIVU a=0x35 b=0x00 -> latency 1, result_o=0xFF, div0_o=1. REMU a=0x35 b=0x00 -> result_o=0x35, div0_o=1.
- N=8, MUL accepted, rst_i high on the 3rd busy cycle -> next cycle: ready_o=1, valid_o=0, result_o=0, all flags 0; no valid_o pulse afterwards.
